ysyx_25030077_wbu: RTL and testbench
====================================

// Module: ysyx_25030077_wbu
// PURPOSE
//  Writeback unit: the result-side counterpart of the operand selector feeding the ALU. Accepts one retiring
//  instruction from EXU via valid/ready and selects the writeback value (ALU result, load data, PC+4 or CSR
//  read). Waits on the LSU read-response channel for loads and formats load data. Drives the register-file
//  write port, then pulses commit so the IFU fetches the next instruction (multi-cycle, one instr in flight).
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register address width
// PORTS
//  clock            in   1       system clock, all state on rising edge
//  reset            in   1       synchronous, active-high
//  io_in_valid      in   1       EXU has an instruction to retire
//  io_in_ready      out  1       WBU can accept (IDLE only)
//  io_in_rd         in   REG_AW  destination register
//  io_in_wen        in   1       instruction writes rd
//  io_in_wb_sel     in   2       0=ALU 1=LOAD 2=PC+4 3=CSR
//  io_in_alu_res    in   XLEN    ALU result; for loads the effective address
//  io_in_pc         in   XLEN    PC of the instruction
//  io_in_csr_data   in   XLEN    old CSR value (csrr*)
//  io_in_load_fmt   in   3       funct3: 000 lb 001 lh 010 lw 100 lbu 101 lhu
//  io_mem_rvalid    in   1       LSU read response valid
//  io_mem_rready    out  1       WBU accepts response (WAIT_MEM only)
//  io_mem_rdata     in   XLEN    aligned word containing load data
//  io_mem_rresp     in   2       0=OKAY, nonzero=error
//  io_rf_wen        out  1       register-file write enable
//  io_rf_waddr      out  REG_AW  register-file write address
//  io_rf_wdata      out  XLEN    register-file write data
//  io_done          out  1       one-cycle commit pulse
//  io_err           out  1       one-cycle fault pulse, coincident with io_done
// BEHAVIOUR
//  - States IDLE, WAIT_MEM, COMMIT. Reset -> IDLE; all captured regs cleared.
//  - Outputs during reset cycle: all 0, including io_in_ready. io_in_ready=1 from first cycle after reset.
//  - IDLE: in_ready=1. On in_valid: capture rd, wen, wb_sel, alu_res, pc, csr_data, load_fmt.
//    LOAD -> WAIT_MEM; else -> COMMIT.
//  - WAIT_MEM: mem_rready=1, in_ready=0. On rvalid: capture rdata and rresp -> COMMIT. Holds indefinitely.
//  - COMMIT (exactly 1 cycle): done=1; rf_wen = wen & (rd!=0) & !fault; waddr=rd; wdata=selected value. -> IDLE.
//  - rf_wen, done, err are 0 outside COMMIT. waddr/wdata are don't-care when rf_wen=0; bench checks only at rf_wen=1.
//  - Latency: non-load accepted at edge T commits in cycle T+1. Load response at edge T2 commits in cycle T2+1.
//    Back-to-back accept earliest at T+2; no combinational in_valid->in_ready or rvalid->rready path.
//  - PC+4: modulo 2^XLEN, so 0xFFFFFFFC -> 0x00000000.
//  - Load format, off=alu_res[1:0]:
//    lb/lbu: byte rdata[8*off+7:8*off], sign/zero-extended.
//    lh/lhu: half at off[1]; sign/zero-extended.
//    lw: whole word.
//  - Fault (err=1, no rf write, done still 1): rresp!=0; lh/lhu with off[0]=1; lw with off!=0; fmt not in set.
//  - rd=0: never written, no fault raised.
//  - Reset mid-WAIT_MEM: instruction dropped, no commit; a late rvalid while IDLE is ignored (rready=0).
//  - in_valid asserted in WAIT_MEM/COMMIT: ignored, EXU must hold it until in_ready.
// TESTING
//  1 ALU: wb_sel=0 rd=5 alu_res=0x12345678 -> next cycle rf_wen=1 waddr=5 wdata=0x12345678 done=1.
//  2 lb: alu_res=0x1003, fmt=000, rdata=0x80FF0000 after 3-cycle stall -> wdata=0xFFFFFF80, commits 1 cycle after rvalid.
//    Same with lhu, alu_res=0x1002, rdata=0x8001BEEF -> wdata=0x00008001.
//  3 jal: wb_sel=2 pc=0xFFFFFFFC rd=1 -> wdata=0x00000000; rd=0 variant -> rf_wen=0 done=1 err=0.
//  4 faults: lw alu_res=0x1001 -> err=1 done=1 rf_wen=0; lw aligned with rresp=2 -> same.
//  5 reset in WAIT_MEM, then rvalid=1 while IDLE -> no rf write, no done, rready=0; next ALU instr commits normally.
//  6 csr: wb_sel=3 csr_data=0xDEADBEEF rd=10 with in_valid held high -> commits, in_ready low in COMMIT, re-accepts at T+2.

Source files
------------

// File: rtl/ysyx_25030077_wbu.sv
// Writeback unit: retires one EXU instruction at a time, waits for the load response when needed,
// formats the writeback value, writes the register file and pulses commit.
module ysyx_25030077_wbu #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   input  logic [REG_AW-1:0] io_in_rd,
   input  logic              io_in_wen,
   input  logic [1:0]        io_in_wb_sel,
   input  logic [XLEN-1:0]   io_in_alu_res,
   input  logic [XLEN-1:0]   io_in_pc,
   input  logic [XLEN-1:0]   io_in_csr_data,
   input  logic [2:0]        io_in_load_fmt,
   input  logic              io_mem_rvalid,
   output logic              io_mem_rready,
   input  logic [XLEN-1:0]   io_mem_rdata,
   input  logic [1:0]        io_mem_rresp,
   output logic              io_rf_wen,
   output logic [REG_AW-1:0] io_rf_waddr,
   output logic [XLEN-1:0]   io_rf_wdata,
   output logic              io_done,
   output logic              io_err
);

   typedef enum logic [1:0] {StIdle, StWaitMem, StCommit} state_e;

   localparam logic [1:0] SelAlu  = 2'd0;
   localparam logic [1:0] SelLoad = 2'd1;
   localparam logic [1:0] SelPc4  = 2'd2;

   state_e              state_q, state_d;
   logic [REG_AW-1:0]   rd_q;
   logic                wen_q;
   logic [1:0]          wb_sel_q;
   logic [XLEN-1:0]     alu_res_q, pc_q, csr_data_q, rdata_q;
   logic [2:0]          load_fmt_q;
   logic [1:0]          rresp_q;

   logic                accept, mem_fire;
   logic [1:0]          off;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [XLEN-1:0]     load_data, wb_data;
   logic                fault;

   assign accept   = (state_q == StIdle) && io_in_valid;
   assign mem_fire = (state_q == StWaitMem) && io_mem_rvalid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         rd_q       <= '0;
         wen_q      <= 1'b0;
         wb_sel_q   <= '0;
         alu_res_q  <= '0;
         pc_q       <= '0;
         csr_data_q <= '0;
         load_fmt_q <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rd_q       <= io_in_rd;
            wen_q      <= io_in_wen;
            wb_sel_q   <= io_in_wb_sel;
            alu_res_q  <= io_in_alu_res;
            pc_q       <= io_in_pc;
            csr_data_q <= io_in_csr_data;
            load_fmt_q <= io_in_load_fmt;
         end
         if (mem_fire) begin
            rdata_q <= io_mem_rdata;
            rresp_q <= io_mem_rresp;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (io_in_valid) state_d = (io_in_wb_sel == SelLoad) ? StWaitMem : StCommit;
         StWaitMem: if (io_mem_rvalid) state_d = StCommit;
         StCommit:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Load extraction works on the captured aligned word; off selects the lane.
   assign off      = alu_res_q[1:0];
   assign byte_sel = rdata_q[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? rdata_q[16 +: 16] : rdata_q[0 +: 16];

   always_comb begin
      load_data = '0;
      fault     = 1'b0;
      if (wb_sel_q == SelLoad) begin
         fault = (rresp_q != 2'd0);
         case (load_fmt_q)
            3'b000: load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: load_data = XLEN'(byte_sel);
            3'b001: begin
               load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
               fault     = fault | off[0];
            end
            3'b101: begin
               load_data = XLEN'(half_sel);
               fault     = fault | off[0];
            end
            3'b010: begin
               load_data = rdata_q;
               fault     = fault | (off != 2'd0);
            end
            default: fault = 1'b1;
         endcase
      end
   end

   always_comb begin
      case (wb_sel_q)
         SelAlu:  wb_data = alu_res_q;
         SelLoad: wb_data = load_data;
         SelPc4:  wb_data = pc_q + XLEN'(4);
         default: wb_data = csr_data_q;
      endcase
   end

   // Outputs are forced low while reset is asserted, whatever state_q holds.
   always_comb begin
      io_in_ready   = 1'b0;
      io_mem_rready = 1'b0;
      io_done       = 1'b0;
      io_err        = 1'b0;
      io_rf_wen     = 1'b0;
      io_rf_waddr   = rd_q;
      io_rf_wdata   = wb_data;
      if (!reset) begin
         case (state_q)
            StIdle:    io_in_ready = 1'b1;
            StWaitMem: io_mem_rready = 1'b1;
            StCommit: begin
               io_done   = 1'b1;
               io_err    = fault;
               io_rf_wen = wen_q && (rd_q != '0) && !fault;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25030077_wbu.sv
// Directed bench for the writeback unit: ALU, load formats, PC+4, CSR, faults and reset recovery.
module tb_ysyx_25030077_wbu;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_wen;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_alu_res, in_pc, in_csr_data;
   logic [2:0]  in_load_fmt;
   logic        mem_rvalid, mem_rready;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        done, err;

   int n_cmp = 0;
   int n_bad = 0;

   // {done, err, rf_wen, in_ready, mem_rready}
   logic [4:0] st;
   assign st = {done, err, rf_wen, in_ready, mem_rready};

   ysyx_25030077_wbu dut (
      .clock          (clock),
      .reset          (reset),
      .io_in_valid    (in_valid),
      .io_in_ready    (in_ready),
      .io_in_rd       (in_rd),
      .io_in_wen      (in_wen),
      .io_in_wb_sel   (in_wb_sel),
      .io_in_alu_res  (in_alu_res),
      .io_in_pc       (in_pc),
      .io_in_csr_data (in_csr_data),
      .io_in_load_fmt (in_load_fmt),
      .io_mem_rvalid  (mem_rvalid),
      .io_mem_rready  (mem_rready),
      .io_mem_rdata   (mem_rdata),
      .io_mem_rresp   (mem_rresp),
      .io_rf_wen      (rf_wen),
      .io_rf_waddr    (rf_waddr),
      .io_rf_wdata    (rf_wdata),
      .io_done        (done),
      .io_err         (err)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] csr,
                        input logic [2:0] fmt);
      in_valid    = 1'b1;
      in_wb_sel   = sel;
      in_rd       = rd;
      in_wen      = wen;
      in_alu_res  = alu;
      in_pc       = pc;
      in_csr_data = csr;
      in_load_fmt = fmt;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_wb_sel = '0;
      in_alu_res = '0; in_pc = '0; in_csr_data = '0; in_load_fmt = '0;
      mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (st !== 5'b00000) begin
         n_bad++; $display("FAIL reset_outputs: got %b want 00000", st);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (st !== 5'b00010) begin
         n_bad++; $display("FAIL post_reset_ready: got %b want 00010", st);
      end
   endtask

   task automatic test_alu();
      @(negedge clock);
      drive(2'd0, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 3'b000);
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++;
      if (st !== 5'b10100 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL alu_commit: got st=%b addr=%0d data=%h want st=10100 addr=5 data=12345678",
                  st, rf_waddr, rf_wdata);
      end
      @(negedge clock);
      n_cmp++;
      if (st !== 5'b00010) begin
         n_bad++; $display("FAIL alu_after: got %b want 00010", st);
      end
      // wen=0 must suppress the write but still commit
      drive(2'd0, 5'd6, 1'b0, 32'hAAAA_5555, 32'h0, 32'h0, 3'b000);
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++;
      if (st !== 5'b10000) begin
         n_bad++; $display("FAIL alu_nowen: got %b want 10000", st);
      end
   endtask

   task automatic test_load_format();
      logic [2:0]  fmt[5]   = '{3'b000, 3'b101, 3'b010, 3'b100, 3'b001};
      logic [31:0] addr[5]  = '{32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h2000};
      logic [31:0] rdat[5]  = '{32'h80FF_0000, 32'h8001_BEEF, 32'hCAFE_BABE,
                                32'h0000_A500, 32'h1234_F00D};
      logic [31:0] expd[5]  = '{32'hFFFF_FF80, 32'h0000_8001, 32'hCAFE_BABE,
                                32'h0000_00A5, 32'hFFFF_F00D};
      int          stall[5] = '{3, 0, 1, 2, 0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         drive(2'd1, 5'd9, 1'b1, addr[i], 32'h0, 32'h0, fmt[i]);
         @(negedge clock);
         in_valid = 1'b0;
         n_cmp++;
         if (st !== 5'b00001) begin
            n_bad++; $display("FAIL load%0d_wait: got %b want 00001", i, st);
         end
         for (int s = 0; s < stall[i]; s++) begin
            @(negedge clock);
            n_cmp++;
            if (st !== 5'b00001) begin
               n_bad++; $display("FAIL load%0d_stall%0d: got %b want 00001", i, s, st);
            end
         end
         mem_rvalid = 1'b1; mem_rdata = rdat[i]; mem_rresp = 2'd0;
         @(negedge clock);
         mem_rvalid = 1'b0;
         n_cmp++;
         if (st !== 5'b10100 || rf_waddr !== 5'd9 || rf_wdata !== expd[i]) begin
            n_bad++;
            $display("FAIL load%0d_commit: got st=%b addr=%0d data=%h want st=10100 addr=9 data=%h",
                     i, st, rf_waddr, rf_wdata, expd[i]);
         end
      end
   endtask

   task automatic test_jal();
      @(negedge clock);
      drive(2'd2, 5'd1, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'b000);
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++;
      if (st !== 5'b10100 || rf_waddr !== 5'd1 || rf_wdata !== 32'h0) begin
         n_bad++;
         $display("FAIL jal_wrap: got st=%b addr=%0d data=%h want st=10100 addr=1 data=00000000",
                  st, rf_waddr, rf_wdata);
      end
      @(negedge clock);
      drive(2'd2, 5'd0, 1'b1, 32'h0, 32'h0000_1000, 32'h0, 3'b000);
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++;
      if (st !== 5'b10000) begin
         n_bad++; $display("FAIL jal_rd0: got %b want 10000", st);
      end
   endtask

   task automatic test_faults();
      logic [2:0]  fmt[4]  = '{3'b010, 3'b010, 3'b001, 3'b011};
      logic [31:0] addr[4] = '{32'h1001, 32'h1000, 32'h1001, 32'h1000};
      logic [1:0]  resp[4] = '{2'd0, 2'd2, 2'd0, 2'd0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         drive(2'd1, 5'd3, 1'b1, addr[i], 32'h0, 32'h0, fmt[i]);
         @(negedge clock);
         in_valid = 1'b0;
         mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; mem_rresp = resp[i];
         @(negedge clock);
         mem_rvalid = 1'b0; mem_rresp = 2'd0;
         n_cmp++;
         if (st !== 5'b11000) begin
            n_bad++; $display("FAIL fault%0d: got %b want 11000", i, st);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clock);
      drive(2'd1, 5'd4, 1'b1, 32'h1000, 32'h0, 32'h0, 3'b010);
      @(negedge clock);
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (st !== 5'b00000) begin
         n_bad++; $display("FAIL midwait_reset: got %b want 00000", st);
      end
      @(negedge clock);
      reset = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      #1;
      n_cmp++;
      if (st !== 5'b00010) begin
         n_bad++; $display("FAIL late_rvalid_idle: got %b want 00010", st);
      end
      @(negedge clock);
      n_cmp++;
      if (st !== 5'b00010) begin
         n_bad++; $display("FAIL late_rvalid_nocommit: got %b want 00010", st);
      end
      mem_rvalid = 1'b0;
      drive(2'd0, 5'd7, 1'b1, 32'h0000_0055, 32'h0, 32'h0, 3'b000);
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++;
      if (st !== 5'b10100 || rf_waddr !== 5'd7 || rf_wdata !== 32'h55) begin
         n_bad++;
         $display("FAIL recover_alu: got st=%b addr=%0d data=%h want st=10100 addr=7 data=00000055",
                  st, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      drive(2'd3, 5'd10, 1'b1, 32'h0, 32'h0, 32'hDEAD_BEEF, 3'b000);
      @(negedge clock);
      n_cmp++;
      if (st !== 5'b10100 || rf_waddr !== 5'd10 || rf_wdata !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL csr_commit: got st=%b addr=%0d data=%h want st=10100 addr=10 data=deadbeef",
                  st, rf_waddr, rf_wdata);
      end
      @(negedge clock);
      n_cmp++;
      if (st !== 5'b00010) begin
         n_bad++; $display("FAIL csr_reaccept_ready: got %b want 00010", st);
      end
      in_csr_data = 32'h0BAD_F00D;
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++;
      if (st !== 5'b10100 || rf_wdata !== 32'h0BAD_F00D) begin
         n_bad++;
         $display("FAIL csr_second: got st=%b data=%h want st=10100 data=0badf00d", st, rf_wdata);
      end
      @(negedge clock);
      n_cmp++;
      if (st !== 5'b00010) begin
         n_bad++; $display("FAIL csr_idle: got %b want 00010", st);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_format();
      test_jal();
      test_faults();
      test_reset_mid_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
